hdlc_rx_channel: RTL
====================

Name: hdlc_rx_channel

Overview:
- Serial receive front end of the Hdlc controller.
- Sits between the Rx/RxEN pins and the Rx frame buffer/control logic, and feeds them destuffed bytes plus frame events.
- Hunts for flags (0x7E), removes stuffed zeros, assembles LSB-first bytes, and reports frame start/end, abort, alignment error and overflow.
- Rx_FlagDetect is the signal the Rx control logic and the bench monitor observe.

Parameters:
MAX_FRAME_BYTES, 128, maximum data bytes accepted between opening and closing flag before overflow.
IDLE_ONES, 15, consecutive raw ones that constitute link idle (used only with the optional feature).

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous active-low reset
Rx  input  1  raw serial receive bit
RxEN  input  1  bit strobe; Rx sampled on a Clk edge only when RxEN=1
Rx_Data  output  8  assembled byte, valid while Rx_ValidByte=1
Rx_ValidByte  output  1  one-cycle pulse per completed data byte
Rx_StartFrame  output  1  one-cycle pulse coincident with first byte of a frame
Rx_EndFrame  output  1  one-cycle pulse at closing flag of a good frame
Rx_FlagDetect  output  1  one-cycle pulse on every flag
Rx_AbortDetect  output  1  one-cycle pulse on abort (7th consecutive one)
Rx_FrameError  output  1  one-cycle pulse at closing flag when destuffed bit count is not a multiple of 8
Rx_Overflow  output  1  one-cycle pulse when byte MAX_FRAME_BYTES+1 completes
Rx_Idle  output  1  level: link idle (optional feature)

Behaviour:
- Reset (Rst=0, async):
  - All outputs 0; Rx_Data=8'h00.
  - Ones counter 0; delay line emptied; byte and bit counters 0; state HUNT.
- RxEN=0: no state changes; pulse outputs return to 0 the next edge.
- Ones counter: increments on sampled 1, saturating at 7; clears on sampled 0.
- Classification of a sampled bit b, using the counter value before update:
  - b=0, ones==5: stuffed zero, tagged drop.
  - b=0, ones==6: flag.
  - b=1, ones==6: abort.
  - Otherwise: normal bit.
- Delay line: 8 entries of {bit, drop, valid}.
  - Each sampled bit enters the line.
  - The entry leaving (8 samples old) is committed as data if valid, not drop, and state is FRAME.
  - Commit is processed before that edge's flag/abort handling.
- Flag:
  - Invalidate all 8 entries.
  - Pulse Rx_FlagDetect on the next cycle.
  - If state FRAME with byte count>0:
    - bit count mod 8 == 0 → pulse Rx_EndFrame.
    - Otherwise → pulse Rx_FrameError.
  - In all cases: state FRAME; counters cleared.
  - Back-to-back flags produce no EndFrame.
- Abort:
  - Pulse Rx_AbortDetect once per run of ones.
  - Invalidate the delay line; discard the partial byte; state HUNT.
- Byte assembly:
  - Committed bits shift right into bit 7.
  - On the 8th bit, Rx_Data is loaded and Rx_ValidByte is pulsed in the following cycle.
  - Rx_StartFrame is pulsed with it when it is the first byte since the flag.
- Overflow:
  - When byte count would exceed MAX_FRAME_BYTES, pulse Rx_Overflow instead of Rx_ValidByte.
  - State HUNT.
- States: HUNT (discard until flag) and FRAME. No other states.
- Latency: a data bit is committed on the 8th RxEN strobe after it was sampled.

Optional Feature:
- HDLC_RX_IDLE_DETECT_EN defined:
  - A separate raw-ones counter, saturating at IDLE_ONES.
  - Rx_Idle=1 from the edge where the count reaches IDLE_ONES until the next sampled 0.
  - Forces state HUNT.
- Not defined: Rx_Idle tied to 0; no extra counter.

Test Plan:
- Reset mid-frame: drop Rst during byte 2 → all outputs 0 within the same cycle; next bit stream ignored until a flag.
- Frame: 7E, 3C, A5, 7E → two Rx_ValidByte pulses (0x3C with Rx_StartFrame, then 0xA5); Rx_EndFrame once; Rx_FlagDetect twice.
- Stuffing: 7E, then raw 1,1,1,1,1,0,1,1,1, then 7E → single byte 0xFF; Rx_EndFrame.
- Abort: 7E, 0x12, then 7 ones → Rx_AbortDetect one pulse; no Rx_EndFrame; subsequent 7E, 0x34, 7E → byte 0x34 with Rx_StartFrame.
- Misalignment: 7E, 0x55, 3 extra zero bits, 7E → Rx_FrameError pulse; no Rx_EndFrame.
- Overflow: MAX_FRAME_BYTES=4, 7E plus 5 bytes → 4 Rx_ValidByte pulses, then Rx_Overflow; closing 7E gives only Rx_FlagDetect.
- With HDLC_RX_IDLE_DETECT_EN: 16 ones → Rx_Idle rises at the 15th, falls after the next 0.
- RxEN gating: RxEN held 0 for 10 cycles mid-byte → output identical to the ungated case.

Source files
------------

// File: rtl/hdlc_rx_channel_if.sv
// ----------------------------------------------------------------------------
// hdlc_rx_channel_if
// Signal bundle between the serial pins and the HDLC receive channel.
//   Rx, RxEN          raw serial bit and its bit strobe
//   Rx_Data           assembled byte, valid while Rx_ValidByte=1
//   Rx_ValidByte      pulse per completed data byte
//   Rx_StartFrame     pulse with the first byte of a frame
//   Rx_EndFrame       pulse at the closing flag of a good frame
//   Rx_FlagDetect     pulse on every flag
//   Rx_AbortDetect    pulse on abort (7th consecutive one)
//   Rx_FrameError     pulse at closing flag of a misaligned frame
//   Rx_Overflow       pulse when a frame exceeds the byte limit
//   Rx_Idle           level, link idle (optional feature)
// slave  : the receive channel (consumes Rx/RxEN, drives the rest)
// master : the pin driver / frame buffer side
// ----------------------------------------------------------------------------
interface hdlc_rx_channel_if;
   logic       Rx;
   logic       RxEN;
   logic [7:0] Rx_Data;
   logic       Rx_ValidByte;
   logic       Rx_StartFrame;
   logic       Rx_EndFrame;
   logic       Rx_FlagDetect;
   logic       Rx_AbortDetect;
   logic       Rx_FrameError;
   logic       Rx_Overflow;
   logic       Rx_Idle;

   modport master (
      output Rx, RxEN,
      input  Rx_Data, Rx_ValidByte, Rx_StartFrame, Rx_EndFrame, Rx_FlagDetect,
             Rx_AbortDetect, Rx_FrameError, Rx_Overflow, Rx_Idle
   );

   modport slave (
      input  Rx, RxEN,
      output Rx_Data, Rx_ValidByte, Rx_StartFrame, Rx_EndFrame, Rx_FlagDetect,
             Rx_AbortDetect, Rx_FrameError, Rx_Overflow, Rx_Idle
   );
endinterface

// File: rtl/hdlc_rx_channel.sv
// ----------------------------------------------------------------------------
// hdlc_rx_channel
// Serial receive front end of the HDLC controller: hunts for 0x7E flags,
// removes stuffed zeros, assembles LSB-first bytes and reports frame events.
// Ports:
//   Clk   system clock, all state on the rising edge
//   Rst   asynchronous active-low reset
//   bus   hdlc_rx_channel_if.slave (Rx/RxEN in, byte and event pulses out)
// Optional feature: define HDLC_RX_IDLE_DETECT_EN to enable link-idle
// detection (Rx_Idle after IDLE_ONES raw ones); otherwise Rx_Idle is 0.
// ----------------------------------------------------------------------------
module hdlc_rx_channel #(
   parameter int MAX_FRAME_BYTES = 128,
   parameter int IDLE_ONES       = 15
) (
   input  logic             Clk,
   input  logic             Rst,
   hdlc_rx_channel_if.slave bus
);
   localparam int              BC_W   = $clog2(MAX_FRAME_BYTES + 1);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_FRAME_BYTES);
   localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);

   // Reject parameter values that make the counters meaningless.
   if (MAX_FRAME_BYTES < 1 || IDLE_ONES < 1) begin : g_param_check
      $error("hdlc_rx_channel: MAX_FRAME_BYTES and IDLE_ONES must be >= 1");
   end

   typedef enum logic {HUNT = 1'b0, FRAME = 1'b1} state_t;

   state_t          state_r, state_s;
   logic [2:0]      ones_r, ones_s;
   // Delay line: bit 0 is the newest sample, bit 7 the one about to leave.
   logic [7:0]      line_bit_r, line_bit_s;
   logic [7:0]      line_drop_r, line_drop_s;
   logic [7:0]      line_valid_r, line_valid_s;
   logic [7:0]      shift_r, shift_s, shift_cat_s;
   logic [2:0]      bit_cnt_r, bit_cnt_s;
   logic [BC_W-1:0] byte_cnt_r, byte_cnt_s;
   logic [7:0]      data_r, data_s;
   logic            valid_r, valid_s, start_r, start_s, end_r, end_s;
   logic            flag_r, flag_s, abort_r, abort_s, err_r, err_s, ovf_r, ovf_s;
   logic            is_drop_s, is_flag_s, is_abort_s, commit_s;

`ifdef HDLC_RX_IDLE_DETECT_EN
   localparam int                IDLE_W   = $clog2(IDLE_ONES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_ONES);
   localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
   logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_s;
   logic              idle_r, idle_s;
`endif

   // Next-state and datapath decode for one strobed bit.
   always_comb begin
      state_s      = state_r;
      ones_s       = ones_r;
      line_bit_s   = line_bit_r;
      line_drop_s  = line_drop_r;
      line_valid_s = line_valid_r;
      shift_s      = shift_r;
      bit_cnt_s    = bit_cnt_r;
      byte_cnt_s   = byte_cnt_r;
      data_s       = data_r;
      valid_s      = 1'b0;
      start_s      = 1'b0;
      end_s        = 1'b0;
      flag_s       = 1'b0;
      abort_s      = 1'b0;
      err_s        = 1'b0;
      ovf_s        = 1'b0;
      is_drop_s    = 1'b0;
      is_flag_s    = 1'b0;
      is_abort_s   = 1'b0;
      commit_s     = 1'b0;
      shift_cat_s  = {line_bit_r[7], shift_r[7:1]};
`ifdef HDLC_RX_IDLE_DETECT_EN
      idle_cnt_s   = idle_cnt_r;
      idle_s       = idle_r;
`endif
      if (bus.RxEN) begin
         // Classification uses the run length before this bit is counted.
         is_drop_s  = !bus.Rx && (ones_r == 3'd5);
         is_flag_s  = !bus.Rx && (ones_r == 3'd6);
         is_abort_s =  bus.Rx && (ones_r == 3'd6);
         if (bus.Rx) begin
            ones_s = (ones_r == 3'd7) ? 3'd7 : ones_r + 3'd1;
         end else begin
            ones_s = 3'd0;
         end
         line_bit_s   = {line_bit_r[6:0], bus.Rx};
         line_drop_s  = {line_drop_r[6:0], is_drop_s};
         line_valid_s = {line_valid_r[6:0], 1'b1};

         // The 8-deep line guarantees flag bits never reach the byte
         // assembler: they are still inside it when the flag is recognised.
         commit_s = line_valid_r[7] && !line_drop_r[7] && (state_r == FRAME);
         if (commit_s) begin
            shift_s = shift_cat_s;
            if (bit_cnt_r == 3'd7) begin
               bit_cnt_s = 3'd0;
               if (byte_cnt_r == BC_MAX) begin
                  ovf_s   = 1'b1;
                  state_s = HUNT;
               end else begin
                  byte_cnt_s = byte_cnt_r + BC_ONE;
                  data_s     = shift_cat_s;
                  valid_s    = 1'b1;
                  start_s    = (byte_cnt_r == '0);
               end
            end else begin
               bit_cnt_s = bit_cnt_r + 3'd1;
            end
         end else begin
            shift_s = shift_r;
         end

         // Flag/abort act on the counters as already updated by the commit.
         case ({is_flag_s, is_abort_s})
            2'b10: begin
               line_valid_s = 8'h00;
               flag_s       = 1'b1;
               if (state_s == FRAME && byte_cnt_s != '0) begin
                  end_s = (bit_cnt_s == 3'd0);
                  err_s = (bit_cnt_s != 3'd0);
               end else begin
                  end_s = 1'b0;
               end
               state_s    = FRAME;
               bit_cnt_s  = 3'd0;
               byte_cnt_s = '0;
            end
            2'b01: begin
               line_valid_s = 8'h00;
               abort_s      = 1'b1;
               state_s      = HUNT;
               bit_cnt_s    = 3'd0;
               byte_cnt_s   = '0;
            end
            default: begin
               commit_s = commit_s;
            end
         endcase

`ifdef HDLC_RX_IDLE_DETECT_EN
         if (bus.Rx) begin
            idle_cnt_s = (idle_cnt_r == IDLE_MAX) ? IDLE_MAX : idle_cnt_r + IDLE_ONE;
            idle_s     = (idle_cnt_s == IDLE_MAX);
         end else begin
            idle_cnt_s = '0;
            idle_s     = 1'b0;
         end
         if (idle_s) begin
            state_s = HUNT;
         end else begin
            idle_cnt_s = idle_cnt_s;
         end
`endif
      end else begin
         ones_s = ones_r;
      end
   end

   // HUNT/FRAME state register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_r <= HUNT;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath registers and registered event outputs.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ones_r       <= 3'd0;
         line_bit_r   <= 8'h00;
         line_drop_r  <= 8'h00;
         line_valid_r <= 8'h00;
         shift_r      <= 8'h00;
         bit_cnt_r    <= 3'd0;
         byte_cnt_r   <= '0;
         data_r       <= 8'h00;
         valid_r      <= 1'b0;
         start_r      <= 1'b0;
         end_r        <= 1'b0;
         flag_r       <= 1'b0;
         abort_r      <= 1'b0;
         err_r        <= 1'b0;
         ovf_r        <= 1'b0;
      end else begin
         ones_r       <= ones_s;
         line_bit_r   <= line_bit_s;
         line_drop_r  <= line_drop_s;
         line_valid_r <= line_valid_s;
         shift_r      <= shift_s;
         bit_cnt_r    <= bit_cnt_s;
         byte_cnt_r   <= byte_cnt_s;
         data_r       <= data_s;
         valid_r      <= valid_s;
         start_r      <= start_s;
         end_r        <= end_s;
         flag_r       <= flag_s;
         abort_r      <= abort_s;
         err_r        <= err_s;
         ovf_r        <= ovf_s;
      end
   end

`ifdef HDLC_RX_IDLE_DETECT_EN
   // Raw-ones run counter and idle level.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         idle_cnt_r <= '0;
         idle_r     <= 1'b0;
      end else begin
         idle_cnt_r <= idle_cnt_s;
         idle_r     <= idle_s;
      end
   end
   assign bus.Rx_Idle = idle_r;
`else
   assign bus.Rx_Idle = 1'b0;
`endif

   assign bus.Rx_Data        = data_r;
   assign bus.Rx_ValidByte   = valid_r;
   assign bus.Rx_StartFrame  = start_r;
   assign bus.Rx_EndFrame    = end_r;
   assign bus.Rx_FlagDetect  = flag_r;
   assign bus.Rx_AbortDetect = abort_r;
   assign bus.Rx_FrameError  = err_r;
   assign bus.Rx_Overflow    = ovf_r;
endmodule
